// File: rtl/line_arbiter_if.sv
// Bundle of the client request bus and the line_drawer handshake shared by
// line_arbiter and whatever drives it (client FSMs plus the drawer).
interface line_arbiter_if #(
    parameter int NUM_REQ = 2
) ();
    // Client side: requests and packed endpoints, 10-bit x and 9-bit y per client
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*10-1:0] x0_in;
    logic [NUM_REQ*9-1:0]  y0_in;
    logic [NUM_REQ*10-1:0] x1_in;
    logic [NUM_REQ*9-1:0]  y1_in;
    logic [NUM_REQ-1:0]    grant;
    logic [NUM_REQ-1:0]    ack;
    logic                  busy;
    logic                  timeout;

    // Drawer side: start pulse, completion and the latched endpoints
    logic                  draw_start;
    logic                  draw_done;
    logic [9:0]            x0;
    logic [8:0]            y0;
    logic [9:0]            x1;
    logic [8:0]            y1;

    // Environment view: clients and the line_drawer
    modport master (
        output req, x0_in, y0_in, x1_in, y1_in, draw_done,
        input  grant, ack, busy, timeout, draw_start, x0, y0, x1, y1
    );

    // Arbiter view
    modport slave (
        input  req, x0_in, y0_in, x1_in, y1_in, draw_done,
        output grant, ack, busy, timeout, draw_start, x0, y0, x1, y1
    );
endinterface

// File: rtl/line_arbiter.sv
// Round-robin arbiter that lends the single line_drawer datapath to one of
// NUM_REQ clients at a time: latch and clamp the winner's endpoints, pulse
// draw_start, wait for draw_done (or a cycle-count timeout), then ack.
module line_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int TIMEOUT = 1048575
) (
    input  logic          clk,
    input  logic          reset_n,
    line_arbiter_if.slave bus
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NSLOT = 2 ** IDXW;

    localparam logic [9:0]      X_MAX    = 10'(WIDTH - 1);
    localparam logic [8:0]      Y_MAX    = 9'(HEIGHT - 1);
    localparam logic [19:0]     CNT_LAST = 20'(TIMEOUT - 1);
    localparam logic [IDXW-1:0] LAST_RST = IDXW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DRAW = 2'd2,
        ACK  = 2'd3
    } state_t;

    function automatic logic [9:0] clamp_x(input logic [9:0] v);
        return (v > X_MAX) ? X_MAX : v;
    endfunction

    function automatic logic [8:0] clamp_y(input logic [8:0] v);
        return (v > Y_MAX) ? Y_MAX : v;
    endfunction

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IDXW-1:0]     win_q, win_d;
    logic [IDXW-1:0]     last_q, last_d;
    logic [9:0]          x0_q, x0_d;
    logic [8:0]          y0_q, y0_d;
    logic [9:0]          x1_q, x1_d;
    logic [8:0]          y1_q, y1_d;
    logic [19:0]         cnt_q, cnt_d;
    logic                to_flag_q, to_flag_d;

    // Per-client endpoint views, padded to a power of two so any index is legal
    logic [9:0]          x0_arr [NSLOT];
    logic [8:0]          y0_arr [NSLOT];
    logic [9:0]          x1_arr [NSLOT];
    logic [8:0]          y1_arr [NSLOT];

    logic                found;
    logic [IDXW-1:0]     win_idx;
    logic [IDXW-1:0]     cand;

    // Unpack the flat client coordinate buses into indexable arrays
    always_comb begin
        for (int i = 0; i < NSLOT; i++) begin
            x0_arr[i] = '0;
            y0_arr[i] = '0;
            x1_arr[i] = '0;
            y1_arr[i] = '0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            x0_arr[i] = bus.x0_in[10*i +: 10];
            y0_arr[i] = bus.y0_in[9*i +: 9];
            x1_arr[i] = bus.x1_in[10*i +: 10];
            y1_arr[i] = bus.y1_in[9*i +: 9];
        end
    end

    // Round-robin search: first pending request after the last served client
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDXW'((int'(last_q) + i) % NUM_REQ);
            if (!found && bus.req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    // State and datapath registers; reset drops everything back to idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            win_q     <= '0;
            last_q    <= LAST_RST;
            x0_q      <= '0;
            y0_q      <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            cnt_q     <= '0;
            to_flag_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            win_q     <= win_d;
            last_q    <= last_d;
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            x1_q      <= x1_d;
            y1_q      <= y1_d;
            cnt_q     <= cnt_d;
            to_flag_q <= to_flag_d;
        end
    end

    // Next-state logic: arbitrate, start the drawer, wait, acknowledge
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        win_d     = win_q;
        last_d    = last_q;
        x0_d      = x0_q;
        y0_d      = y0_q;
        x1_d      = x1_q;
        y1_d      = y1_q;
        cnt_d     = cnt_q;
        to_flag_d = to_flag_q;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d   = LOAD;
                    grant_d   = NUM_REQ'(1) << win_idx;
                    win_d     = win_idx;
                    x0_d      = clamp_x(x0_arr[win_idx]);
                    y0_d      = clamp_y(y0_arr[win_idx]);
                    x1_d      = clamp_x(x1_arr[win_idx]);
                    y1_d      = clamp_y(y1_arr[win_idx]);
                    to_flag_d = 1'b0;
                end
            end
            LOAD: begin
                // draw_done is deliberately not looked at here: a level held
                // over from the previous line must not finish this one.
                cnt_d   = '0;
                state_d = DRAW;
            end
            DRAW: begin
                cnt_d = cnt_q + 20'd1;
                if (bus.draw_done) begin
                    to_flag_d = 1'b0;
                    state_d   = ACK;
                end else if (cnt_q == CNT_LAST) begin
                    to_flag_d = 1'b1;
                    state_d   = ACK;
                end
            end
            ACK: begin
                last_d  = win_q;
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registers or plain state decodes; nothing combinational from req
    assign bus.grant      = grant_q;
    assign bus.ack        = (state_q == ACK) ? grant_q : '0;
    assign bus.timeout    = (state_q == ACK) && to_flag_q;
    assign bus.draw_start = (state_q == LOAD);
    assign bus.busy       = (state_q != IDLE);
    assign bus.x0         = x0_q;
    assign bus.y0         = y0_q;
    assign bus.x1         = x1_q;
    assign bus.y1         = y1_q;

endmodule

// File: tb/tb_line_arbiter.sv
// Directed bench for line_arbiter: reset, first grant, stale done, single
// long draw, round-robin rotation, clamping, mid-draw reset and timeout.
module tb_line_arbiter;

    logic clk = 1'b0;
    logic reset_n;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    line_arbiter_if #(.NUM_REQ(2)) bus ();
    line_arbiter_if #(.NUM_REQ(2)) bus_t ();

    line_arbiter #(.NUM_REQ(2), .WIDTH(640), .HEIGHT(480), .TIMEOUT(1048575)) u_dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    line_arbiter #(.NUM_REQ(2), .WIDTH(640), .HEIGHT(480), .TIMEOUT(16)) u_dut_to (
        .clk(clk), .reset_n(reset_n), .bus(bus_t)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_xy(input int k, input int ax0, input int ay0, input int ax1, input int ay1);
        bus.x0_in[10*k +: 10] = 10'(ax0);
        bus.y0_in[9*k +: 9]   = 9'(ay0);
        bus.x1_in[10*k +: 10] = 10'(ax1);
        bus.y1_in[9*k +: 9]   = 9'(ay1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ds_cnt, ds_at, ack_cnt, ack_at, to_cnt, to_at_ack;
        int n, acks, since;
        logic [1:0]  ack_val;
        logic [37:0] ep_load, ep_mid;
        logic [1:0]  gs [4];
        logic [1:0]  as_ [4];
        logic [1:0]  rr_exp [4];

        rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
        for (int i = 0; i < 4; i++) begin gs[i] = '0; as_[i] = '0; end
        ep_load = '0; ep_mid = '0;

        // Reset with both clients requesting
        reset_n = 1'b0;
        bus.req = 2'b11;
        bus.draw_done = 1'b0;
        bus.x0_in = '0; bus.y0_in = '0; bus.x1_in = '0; bus.y1_in = '0;
        set_xy(0, 1, 2, 3, 4);
        set_xy(1, 100, 101, 102, 103);
        bus_t.req = 2'b00;
        bus_t.draw_done = 1'b0;
        bus_t.x0_in = '0; bus_t.y0_in = '0; bus_t.x1_in = '0; bus_t.y1_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_grant", bus.grant, 2'b00);
        chk("rst_ack", bus.ack, 2'b00);
        chk("rst_draw_start", bus.draw_start, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_timeout", bus.timeout, 1'b0);
        chk("rst_x0", bus.x0, 10'd0);
        chk("rst_y1", bus.y1, 9'd0);

        // Release: client 0 wins first; done raised during LOAD is stale
        reset_n = 1'b1;
        @(negedge clk);
        chk("first_grant", bus.grant, 2'b01);
        chk("first_draw_start", bus.draw_start, 1'b1);
        chk("first_busy", bus.busy, 1'b1);
        chk("first_x1", bus.x1, 10'd3);
        bus.req = 2'b00;
        bus.draw_done = 1'b1;
        @(negedge clk);
        chk("stale_done_no_ack", bus.ack, 2'b00);
        chk("stale_done_grant", bus.grant, 2'b01);
        chk("stale_done_ds_low", bus.draw_start, 1'b0);
        @(negedge clk);
        chk("first_ack", bus.ack, 2'b01);
        chk("first_timeout", bus.timeout, 1'b0);
        bus.draw_done = 1'b0;
        @(negedge clk);
        chk("idle_busy", bus.busy, 1'b0);
        chk("idle_grant", bus.grant, 2'b00);
        chk("idle_ack", bus.ack, 2'b00);

        // Single request from client 1, done 50 cycles after draw_start
        set_xy(1, 10, 20, 300, 200);
        bus.req = 2'b10;
        ds_cnt = 0; ds_at = -1; ack_cnt = 0; ack_at = -1; to_cnt = 0; ack_val = '0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (bus.draw_start) begin
                ds_cnt++;
                if (ds_at < 0) begin
                    ds_at = c;
                    ep_load = {bus.x0, bus.y0, bus.x1, bus.y1};
                end
            end
            if (bus.ack != 2'b00) begin
                ack_cnt++;
                ack_at = c;
                ack_val = bus.ack;
                bus.req = 2'b00;
            end
            if (bus.timeout) to_cnt++;
            if (ds_at >= 0 && c == ds_at + 5) set_xy(1, 5, 6, 7, 8);
            if (ds_at >= 0 && c == ds_at + 40) ep_mid = {bus.x0, bus.y0, bus.x1, bus.y1};
            if (ds_at >= 0 && c == ds_at + 50) bus.draw_done = 1'b1;
            if (ds_at >= 0 && c == ds_at + 51) bus.draw_done = 1'b0;
        end
        chk("single_ds_count", ds_cnt, 1);
        chk("single_ack_count", ack_cnt, 1);
        chk("single_ack_latency", ack_at - ds_at, 51);
        chk("single_ack_value", ack_val, 2'b10);
        chk("single_timeout", to_cnt, 0);
        chk("single_endpoints", ep_load, {10'd10, 9'd20, 10'd300, 9'd200});
        chk("single_endpoints_stable", ep_mid, {10'd10, 9'd20, 10'd300, 9'd200});

        // Both clients held: grants alternate starting with client 0
        bus.req = 2'b11;
        n = 0; acks = 0; since = 0;
        for (int c = 0; c < 200 && acks < 4; c++) begin
            @(negedge clk);
            if (bus.draw_start) begin
                if (n < 4) gs[n] = bus.grant;
                n++;
                since = 0;
            end else begin
                since++;
            end
            if (bus.ack != 2'b00) begin
                if (acks < 4) as_[acks] = bus.ack;
                acks++;
                bus.draw_done = 1'b0;
            end else if (since == 5) begin
                bus.draw_done = 1'b1;
            end
        end
        bus.req = 2'b00;
        bus.draw_done = 1'b0;
        chk("rr_ack_count", acks, 4);
        chk("rr_grant_count", n, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_grant_%0d", i), gs[i], rr_exp[i]);
            chk($sformatf("rr_ack_%0d", i), as_[i], rr_exp[i]);
        end
        @(negedge clk);

        // Clamping of out-of-range endpoints; 479 sits exactly on the limit
        set_xy(0, 700, 479, 1023, 500);
        bus.req = 2'b01;
        @(negedge clk);
        chk("clamp_grant", bus.grant, 2'b01);
        chk("clamp_x0", bus.x0, 10'd639);
        chk("clamp_y0", bus.y0, 9'd479);
        chk("clamp_x1", bus.x1, 10'd639);
        chk("clamp_y1", bus.y1, 9'd479);
        bus.draw_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("clamp_ack", bus.ack, 2'b01);
        bus.draw_done = 1'b0;
        bus.req = 2'b00;
        @(negedge clk);

        // Reset in the middle of a draw: no ack, pointer back to client 0
        bus.req = 2'b10;
        @(negedge clk);
        chk("midrst_grant", bus.grant, 2'b10);
        repeat (3) @(negedge clk);
        chk("midrst_drawing", bus.busy, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("midrst_grant_clear", bus.grant, 2'b00);
        chk("midrst_busy_clear", bus.busy, 1'b0);
        chk("midrst_x0_clear", bus.x0, 10'd0);
        bus.req = 2'b11;
        ack_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.ack != 2'b00) ack_cnt++;
        end
        chk("midrst_no_ack", ack_cnt, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("midrst_ptr_reset", bus.grant, 2'b01);
        bus.draw_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_next_ack", bus.ack, 2'b01);
        bus.draw_done = 1'b0;
        bus.req = 2'b00;

        // TIMEOUT=16 instance: no done, forced completion after 16 DRAW cycles
        bus_t.req = 2'b01;
        ds_at = -1; ack_at = -1; to_cnt = 0; to_at_ack = -1; ack_val = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus_t.draw_start && ds_at < 0) ds_at = c;
            if (bus_t.timeout) to_cnt++;
            if (bus_t.ack != 2'b00 && ack_at < 0) begin
                ack_at = c;
                ack_val = bus_t.ack;
                to_at_ack = int'(bus_t.timeout);
                bus_t.req = 2'b00;
            end
        end
        chk("to_ack_latency", ack_at - ds_at, 17);
        chk("to_ack_value", ack_val, 2'b01);
        chk("to_flag_with_ack", to_at_ack, 1);
        chk("to_pulse_count", to_cnt, 1);

        // Next request: done lands on the final allowed cycle and wins
        bus_t.req = 2'b10;
        ds_at = -1; ack_at = -1; to_cnt = 0; to_at_ack = -1; ack_val = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus_t.draw_start && ds_at < 0) ds_at = c;
            if (bus_t.timeout) to_cnt++;
            if (bus_t.ack != 2'b00 && ack_at < 0) begin
                ack_at = c;
                ack_val = bus_t.ack;
                to_at_ack = int'(bus_t.timeout);
                bus_t.req = 2'b00;
                bus_t.draw_done = 1'b0;
            end
            if (ds_at >= 0 && c == ds_at + 16) bus_t.draw_done = 1'b1;
        end
        bus_t.draw_done = 1'b0;
        chk("done_wins_latency", ack_at - ds_at, 17);
        chk("done_wins_ack", ack_val, 2'b10);
        chk("done_wins_flag", to_at_ack, 0);
        chk("done_wins_pulses", to_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
